alu_trace_capture: RTL
======================

Name: alu_trace_capture

Overview:
- Writer-side counterpart to the ALU test-vector flow: it samples live ALU interface traffic {op, ext, misc, src_data, dest_data, res} into an on-chip buffer.
- Each entry has the same bit layout as the ALU test-vector file, so a captured trace can be read back and replayed as a vector file.
- Sits beside the alu instance. Driven by a capture strobe from the sequencer; drained through a simple pop-style read port.

Parameters:
- DATA_SIZE, 5, width of src_data/dest_data.
- OP_SIZE, 3, width of op.
- RES_SIZE, 16, width of res.
- DEPTH, 16, number of buffer entries; must be a power of two and at least 2.
- VEC_W, 2*DATA_SIZE+OP_SIZE+RES_SIZE+2, derived entry width; 31 at defaults.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  start a new capture (clears buffer).
- stop  in  1  end capture early.
- sample  in  1  capture strobe; the ALU tuple is valid this cycle.
- op  in  OP_SIZE  ALU opcode.
- ext  in  1  ALU ext control.
- misc  in  1  ALU misc control.
- src_data  in  DATA_SIZE  ALU source operand.
- dest_data  in  DATA_SIZE  ALU destination operand.
- res  in  RES_SIZE  ALU result.
- rd_req  in  1  pop one entry.
- rd_data  out  VEC_W  popped entry {op, ext, misc, src_data, dest_data, res}, MSB first.
- rd_valid  out  1  rd_data valid (one-cycle pulse).
- count  out  $clog2(DEPTH)+1  entries written.
- capturing  out  1  high in CAPTURE.
- done  out  1  high in DONE.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a sample was dropped because the buffer was full.

Behaviour:
- Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0, rd_data=0. rd_valid, capturing, done, full and overflow are all 0. Buffer contents are don't-care. Reset takes effect in any state, including mid-capture and mid-readout.
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - arm -> CAPTURE; wr_ptr, rd_ptr, count and overflow are cleared.
  - sample, stop and rd_req are ignored.
- CAPTURE:
  - sample=1 writes the concatenated tuple at wr_ptr and increments wr_ptr and count on the same edge.
  - When the write makes count==DEPTH -> DONE on that edge; full=1.
  - stop=1 -> DONE. If sample and stop are both high in the same cycle, the sample is written first.
  - arm and rd_req are ignored.
- DONE:
  - rd_req=1 with rd_ptr<count: rd_data=mem[rd_ptr] and rd_valid=1 on the next edge (latency 1); rd_ptr increments.
  - rd_req with rd_ptr==count: rd_valid=0, rd_data holds its last value.
  - sample=1 while full=1 sets overflow. sample while not full is ignored and sets nothing.
  - arm -> CAPTURE with all clears, exactly as from IDLE. arm has priority over a simultaneous rd_req, which is dropped.
- Output timing: rd_valid is high only in the cycle after an accepted rd_req. Back-to-back rd_req returns consecutive entries every cycle.
- Pointers are log2(DEPTH) bits. wr_ptr wraps to 0 at DEPTH, but no write occurs after full. count saturates at DEPTH.
- Entry 0 is the oldest sample. Readout order is strictly write order.

Optional Feature:
- Macro: ALU_TRACE_DEDUP_EN.
- Defined:
  - A sample whose tuple equals the last written tuple is not stored, and count is unchanged.
  - The compare register is invalidated on arm and rst, so the first sample after arm is always stored.
  - Dropped duplicates do not set overflow.
- Undefined: every sample in CAPTURE is stored, and no compare register is built.

Test Plan:
- Capture and readout: rst, then arm. Give 3 samples: (op=3'b010,ext=0,misc=1,src=5,dest=9,res=16'd14), (op=0,src=1,dest=2,res=3), (op=7,src=31,dest=31,res=16'hFFFF). Then stop, then 4 back-to-back rd_req. Expect count=3 and done=1. rd_data must equal the three 31-bit concatenations in order with rd_valid high for 3 cycles; the fourth rd_req gives rd_valid=0.
- Fill and overflow: arm, then 17 consecutive samples with res=0..16. Expect DONE entered on the 16th write with full=1 and count=16. Then overflow=1; reading 16 entries returns res=0..15.
- Simultaneous sample and stop: arm, then sample(res=16'h00AA) with stop in the same cycle. Expect count=1 and done=1; readout gives res=16'h00AA.
- Reset mid-capture: arm, 5 samples, then assert rst for 1 cycle. Expect all outputs 0 and state IDLE. A following sample without arm leaves count=0.
- Re-arm during readout: capture 4 entries and read 2, then arm with a simultaneous rd_req. Expect rd_valid=0, count=0, capturing=1 and overflow=0.
- ALU_TRACE_DEDUP_EN: arm, then samples A, A, B, A. Expect count=3 and readout A, B, A. With the macro undefined, expect count=4.

Source files
------------

// File: rtl/alu_trace_capture.sv
// alu_trace_capture: samples live ALU traffic {op, ext, misc, src_data, dest_data, res}
// into an on-chip buffer. Each entry uses the ALU test-vector bit layout, so a drained trace
// can be replayed as a vector file.
// Optional build macro: ALU_TRACE_DEDUP_EN. When it is defined, a sample equal to the last
// stored tuple is dropped.
module alu_trace_capture #(
  parameter int unsigned DATA_SIZE = 5,
  parameter int unsigned OP_SIZE   = 3,
  parameter int unsigned RES_SIZE  = 16,
  parameter int unsigned DEPTH     = 16,
  localparam int unsigned VEC_W    = 2 * DATA_SIZE + OP_SIZE + RES_SIZE + 2,
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 stop,
  input  logic                 sample,
  input  logic [OP_SIZE-1:0]   op,
  input  logic                 ext,
  input  logic                 misc,
  input  logic [DATA_SIZE-1:0] src_data,
  input  logic [DATA_SIZE-1:0] dest_data,
  input  logic [RES_SIZE-1:0]  res,
  input  logic                 rd_req,
  output logic [VEC_W-1:0]     rd_data,
  output logic                 rd_valid,
  output logic [CW-1:0]        count,
  output logic                 capturing,
  output logic                 done,
  output logic                 full,
  output logic                 overflow
);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q;
  // Read index is one bit wider than the pointer so a full buffer can be drained exactly
  // once; rd_ptr is its low bits.
  logic [CW-1:0]      rd_idx_q;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic [VEC_W-1:0]   rd_data_q;
  logic               rd_valid_q;
  logic               overflow_q;
  logic [VEC_W-1:0]   mem [DEPTH];

  logic [VEC_W-1:0]   tuple;
  logic               dup;
  logic               full_int;
  logic               arm_go;
  logic               wr_en;
  logic               last_write;
  logic               rd_go;
  logic               ovf_set;

  assign tuple  = {op, ext, misc, src_data, dest_data, res};
  assign rd_ptr = rd_idx_q[PW-1:0];

  // Decode the per-cycle actions from the current state and strobes.
  always_comb begin
    full_int   = (count_q == CW'(DEPTH));
    arm_go     = arm && (state_q != StCapture);
    wr_en      = (state_q == StCapture) && sample && !dup;
    last_write = wr_en && (count_q == CW'(DEPTH - 1));
    // arm wins over a simultaneous rd_req in DONE; the read is dropped.
    rd_go      = (state_q == StDone) && rd_req && !arm && (rd_idx_q < count_q);
    ovf_set    = (state_q == StDone) && sample && full_int && !arm_go;
  end

`ifdef ALU_TRACE_DEDUP_EN
  logic [VEC_W-1:0] last_q;
  logic             last_valid_q;

  // Track the most recently stored tuple; invalidated on arm so the first sample is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid_q <= 1'b0;
    end else if (arm_go) begin
      last_valid_q <= 1'b0;
    end else if (wr_en) begin
      last_valid_q <= 1'b1;
      last_q       <= tuple;
    end
  end

  assign dup = last_valid_q && (tuple == last_q);
`else
  assign dup = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StCapture;
      end
      StCapture: begin
        // A sample coinciding with stop is still written by the datapath this edge.
        if (last_write || stop) state_d = StDone;
      end
      StDone: begin
        if (arm) state_d = StCapture;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    capturing = (state_q == StCapture);
    done      = (state_q == StDone);
    full      = full_int;
  end

  // Pointers, count, read port and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        rd_data_q <= mem[rd_ptr];
        rd_idx_q  <= rd_idx_q + 1'b1;
      end
      if (arm_go) begin
        wr_ptr_q   <= '0;
        rd_idx_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          count_q  <= count_q + 1'b1;
        end
        if (ovf_set) overflow_q <= 1'b1;
      end
    end
  end

  // Buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= tuple;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
